// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the PE row scheduler.
// Consumers import diff_demo_pkg::*.
package diff_demo_pkg;

   localparam int GUARD_W = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/pe_row_scheduler_col_track.sv
// Per-column issue/finish tracking for pe_row_scheduler.
// Holds one column's issue_mask / fin_mask bit pair.
module pe_col_track (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic load_en,
   input  logic in_issue,
   input  logic in_track,
   input  logic fifo_full,
   input  logic ctrl_ready,
   input  logic ctrl_finish,
   output logic ctrl_valid,
   output logic issue_nxt,
   output logic fin_nxt
);

   logic issue_q;
   logic fin_q;

   // A finish is only meaningful once the column has been handed its job.
   always_comb begin
      ctrl_valid = in_issue && issue_q && !fifo_full;
      issue_nxt  = issue_q;
      fin_nxt    = fin_q;
      if (load) begin
         issue_nxt = load_en;
         fin_nxt   = load_en;
      end else begin
         if (ctrl_valid && ctrl_ready) begin
            issue_nxt = 1'b0;
         end
         if (in_track && ctrl_finish && !issue_q) begin
            fin_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_q <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         issue_q <= issue_nxt;
         fin_q   <= fin_nxt;
      end
   end

endmodule

// File: rtl/pe_row_scheduler.sv
// Row-descriptor sequencer across N_COL PE column controllers.
// Optional PE_SCHED_SKIP_EMPTY_EN: skip columns with no work.
module pe_row_scheduler
   import diff_demo_pkg::*;
#(
   parameter int N_COL     = 4,
   parameter int ROW_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     desc_valid,
   output logic                     desc_ready,
   input  logic [N_COL*GUARD_W-1:0] desc_guard_map,
   input  logic                     desc_bit_mode,
   input  logic                     desc_kernel_mode,
   input  logic                     desc_is_odd_row,
   input  logic                     desc_end_of_row,
   input  logic                     fifo_full,
   output logic [N_COL-1:0]         col_ctrl_valid,
   input  logic [N_COL-1:0]         col_ctrl_ready,
   input  logic [N_COL-1:0]         col_ctrl_finish,
   output logic [N_COL*GUARD_W-1:0] col_guard_map,
   output logic                     col_bit_mode,
   output logic                     col_kernel_mode,
   output logic                     col_is_odd_row,
   output logic                     col_end_of_row,
   output logic                     row_done,
   output logic                     layer_done,
   output logic [ROW_CNT_W-1:0]     row_cnt,
   output logic                     busy
);

   sched_state_t state_q;
   sched_state_t state_d;

   logic             accept;
   logic [N_COL-1:0] col_en;
   logic [N_COL-1:0] issue_nxt;
   logic [N_COL-1:0] fin_nxt;

   assign desc_ready = (state_q == S_IDLE) && !fifo_full;
   assign accept     = desc_ready && desc_valid;

   for (genvar i = 0; i < N_COL; i++) begin : g_col
`ifdef PE_SCHED_SKIP_EMPTY_EN
      assign col_en[i] = (|desc_guard_map[i*GUARD_W +: GUARD_W])
                       || desc_bit_mode;
`else
      assign col_en[i] = 1'b1;
`endif

      pe_col_track u_track (
         .clk         (clk),
         .rst         (rst),
         .load        (accept),
         .load_en     (col_en[i]),
         .in_issue    (state_q == S_ISSUE),
         .in_track    ((state_q == S_ISSUE) || (state_q == S_WAIT)),
         .fifo_full   (fifo_full),
         .ctrl_ready  (col_ctrl_ready[i]),
         .ctrl_finish (col_ctrl_finish[i]),
         .ctrl_valid  (col_ctrl_valid[i]),
         .issue_nxt   (issue_nxt[i]),
         .fin_nxt     (fin_nxt[i])
      );
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (|col_en) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            if (issue_nxt == '0) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fin_nxt == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Column-facing data is held from one acceptance to the next.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_guard_map   <= '0;
         col_bit_mode    <= 1'b0;
         col_kernel_mode <= 1'b0;
         col_is_odd_row  <= 1'b0;
         col_end_of_row  <= 1'b0;
      end else if (accept) begin
         col_guard_map   <= desc_guard_map;
         col_bit_mode    <= desc_bit_mode;
         col_kernel_mode <= desc_kernel_mode;
         col_is_odd_row  <= desc_is_odd_row;
         col_end_of_row  <= desc_end_of_row;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt <= '0;
      end else if (state_q == S_DONE) begin
         if (col_end_of_row) begin
            row_cnt <= '0;
         end else begin
            row_cnt <= row_cnt + 1'b1;
         end
      end
   end

   assign row_done   = (state_q == S_DONE);
   assign layer_done = row_done && col_end_of_row;
   assign busy       = (state_q != S_IDLE);

endmodule
